// File: rtl/inference_sched.sv
// Frame loader / result streamer for the MLP inference core: scatters one input frame into A/B/C RAMs, starts the core, streams RES out.
// Optional Done watchdog enabled by defining INF_TIMEOUT_EN.
module inference_sched #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 4,
  parameter int C_depth_bits   = 2,
  parameter int RES_depth_bits = 6,
  parameter int NUM_A          = 448,
  parameter int NUM_B          = 16,
  parameter int NUM_C          = 3,
  parameter int NUM_RES        = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  input  logic [width-1:0]          s_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [width-1:0]          m_data,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      C_write_en,
  output logic [C_depth_bits-1:0]   C_write_address,
  output logic [width-1:0]          C_write_data_in,
  output logic [width-1:0]          hidden_layer_bias_one,
  output logic [width-1:0]          hidden_layer_bias_two,
  output logic [width-1:0]          output_layer_bias,
  output logic                      inf_start,
  input  logic                      inf_done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, START, WAIT_DONE, RD_RES, OUT} state_t;

  localparam logic [A_depth_bits-1:0]   CNT0   = '0;
  localparam logic [A_depth_bits-1:0]   CNT1   = A_depth_bits'(1);
  localparam logic [A_depth_bits-1:0]   A_LAST = A_depth_bits'(NUM_A - 1);
  localparam logic [A_depth_bits-1:0]   B_LAST = A_depth_bits'(NUM_B - 1);
  localparam logic [A_depth_bits-1:0]   C_LAST = A_depth_bits'(NUM_C - 1);
  localparam logic [RES_depth_bits-1:0] K_LAST = RES_depth_bits'(NUM_RES - 1);

  state_t                    state_q;
  logic                      live_q;
  logic [A_depth_bits-1:0]   cnt_q, waddr_q;
  logic [width-1:0]          wdat_q, bias1_q, bias2_q, obias_q;
  logic                      a_we_q, b_we_q, c_we_q;
  logic                      start_q, done_q, re_q, mv_q, ml_q, err_q;
  logic [RES_depth_bits-1:0] k_q;
`ifdef INF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // START counts as the first watchdog cycle, so expiry lands TIMEOUT_CYCLES after the pulse
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  logic [TW-1:0] tmo_q;
`endif

  logic beat, final_word;
  assign s_ready    = live_q && (state_q inside {IDLE, LOAD_A, LOAD_B, LOAD_C});
  assign beat       = s_valid && s_ready;
  assign final_word = (state_q == LOAD_C) && (cnt_q == C_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdat_q  <= '0;
      bias1_q <= '0;
      bias2_q <= '0;
      obias_q <= '0;
      a_we_q  <= 1'b0;
      b_we_q  <= 1'b0;
      c_we_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
`ifdef INF_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      live_q  <= 1'b1;
      a_we_q  <= 1'b0;
      b_we_q  <= 1'b0;
      c_we_q  <= 1'b0;
      start_q <= 1'b0;
      re_q    <= 1'b0;
      unique case (state_q)
        IDLE: if (beat) begin
          // a new frame clears the sticky error unless its very first beat is already an early last
          err_q   <= s_last;
          a_we_q  <= 1'b1;
          waddr_q <= '0;
          wdat_q  <= s_data;
          if (!s_last) begin
            cnt_q   <= CNT1;
            state_q <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B, LOAD_C: if (beat) begin
          waddr_q <= cnt_q;
          wdat_q  <= s_data;
          cnt_q   <= cnt_q + 1'b1;
          if (state_q == LOAD_A) begin
            a_we_q <= 1'b1;
            if (cnt_q == A_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end
          end else if (state_q == LOAD_B) begin
            b_we_q <= 1'b1;
            if (cnt_q == CNT0) bias1_q <= s_data;
            if (cnt_q == CNT1) bias2_q <= s_data;
            if (cnt_q == B_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_C;
            end
          end else begin
            c_we_q <= 1'b1;
            if (cnt_q == CNT0) obias_q <= s_data;
            if (cnt_q == C_LAST) begin
              cnt_q   <= '0;
              state_q <= START;
              start_q <= 1'b1;
              if (!s_last) err_q <= 1'b1;
            end
          end
          if (s_last && !final_word) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        START: begin
          done_q  <= inf_done;
          state_q <= WAIT_DONE;
`ifdef INF_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        WAIT_DONE: begin
          done_q <= inf_done;
          if (inf_done && !done_q) begin
            k_q     <= '0;
            re_q    <= 1'b1;
            state_q <= RD_RES;
          end
`ifdef INF_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RD_RES: begin
          mv_q    <= 1'b1;
          ml_q    <= (k_q == K_LAST);
          state_q <= OUT;
        end
        OUT: if (m_ready) begin
          mv_q <= 1'b0;
          ml_q <= 1'b0;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= IDLE;
          end else begin
            k_q     <= k_q + 1'b1;
            re_q    <= 1'b1;
            state_q <= RD_RES;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RES RAM output register holds its word while read_en stays low, so it is the stalled m_data
  assign m_data                = mv_q ? RES_read_data_out : '0;
  assign m_valid               = mv_q;
  assign m_last                = ml_q;
  assign A_write_en            = a_we_q;
  assign A_write_address       = waddr_q;
  assign A_write_data_in       = wdat_q;
  assign B_write_en            = b_we_q;
  assign B_write_address       = waddr_q[B_depth_bits-1:0];
  assign B_write_data_in       = wdat_q;
  assign C_write_en            = c_we_q;
  assign C_write_address       = waddr_q[C_depth_bits-1:0];
  assign C_write_data_in       = wdat_q;
  assign hidden_layer_bias_one = bias1_q;
  assign hidden_layer_bias_two = bias2_q;
  assign output_layer_bias     = obias_q;
  assign inf_start             = start_q;
  assign RES_read_en           = re_q;
  assign RES_read_address      = k_q;
  assign busy                  = (state_q != IDLE);
  assign err                   = err_q;

endmodule
